f2d_arbiter: RTL and testbench

Round-robin controller sharing one float-to-double converter (`f2d` unit) between `NUM_REQ` requesters. It accepts a single-precision operand from one requester at a time and sequences the converter through its reset-release / run / done cycle. It then returns the 64-bit result, NaN flag and requester ID on a valid/ready response port. It sits between the FPU issue logic and the single converter instance.

---
 rtl/f2d_arbiter.sv | 150 +++++++++++++++
 tb/tb_f2d_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/f2d_arbiter.sv
// rtl/f2d_arbiter.sv - round-robin arbiter sharing one float-to-double converter
// Optional converter watchdog enabled by defining F2D_ARB_TIMEOUT_EN.
module f2d_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 15,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [32*NUM_REQ-1:0]  req_float,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [ID_W-1:0]        resp_id,
  output logic [63:0]            resp_double,
  output logic                   resp_nan,
  output logic                   busy,
  output logic                   timeout_err,
  output logic                   cvt_reset,
  output logic [31:0]            cvt_float,
  input  logic [63:0]            cvt_double,
  input  logic                   cvt_done,
  input  logic                   cvt_nan
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t          state;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] grant_idx;
  logic            grant_hit;
  logic [ID_W:0]   cand;
  logic [31:0]     grant_float;
  logic [ID_W-1:0] next_ptr;

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 1) begin : g_param_check
    $error("f2d_arbiter: NUM_REQ must be 2..8 and TIMEOUT at least 1");
  end

  // Scan downward so the candidate closest to rr_ptr is the last one written.
  always_comb begin
    grant_hit = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = {1'b0, rr_ptr} + (ID_W+1)'(k);
      if (cand >= (ID_W+1)'(NUM_REQ)) begin
        cand = cand - (ID_W+1)'(NUM_REQ);
      end
      if (req_valid[cand[ID_W-1:0]]) begin
        grant_hit = 1'b1;
        grant_idx = cand[ID_W-1:0];
      end
    end
  end

  always_comb begin
    req_ready   = '0;
    grant_float = req_float[31:0];
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == ID_W'(i)) begin
        grant_float = req_float[32*i +: 32];
      end
    end
    if (state == S_IDLE && grant_hit) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  assign next_ptr = (resp_id == ID_W'(NUM_REQ - 1)) ? '0 : resp_id + 1'b1;

`ifdef F2D_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] run_cnt;
`else
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      rr_ptr      <= '0;
      resp_valid  <= 1'b0;
      resp_id     <= '0;
      resp_double <= '0;
      resp_nan    <= 1'b0;
      busy        <= 1'b0;
      cvt_reset   <= 1'b0;
      cvt_float   <= '0;
`ifdef F2D_ARB_TIMEOUT_EN
      run_cnt     <= '0;
      timeout_err <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (grant_hit) begin
            cvt_float <= grant_float;
            resp_id   <= grant_idx;
            cvt_reset <= 1'b1;
            busy      <= 1'b1;
            state     <= S_RUN;
`ifdef F2D_ARB_TIMEOUT_EN
            run_cnt   <= '0;
`endif
          end
        end
        S_RUN: begin
          if (cvt_done) begin
            resp_double <= cvt_double;
            resp_nan    <= cvt_nan;
            resp_valid  <= 1'b1;
            cvt_reset   <= 1'b0;
            state       <= S_RESP;
          end
`ifdef F2D_ARB_TIMEOUT_EN
          // Abort at the end of the TIMEOUT-th RUN cycle with a canonical quiet NaN.
          else if (run_cnt == CNT_W'(TIMEOUT - 1)) begin
            resp_double <= 64'h7FF8000000000000;
            resp_nan    <= 1'b1;
            resp_valid  <= 1'b1;
            cvt_reset   <= 1'b0;
            timeout_err <= 1'b1;
            state       <= S_RESP;
          end else begin
            run_cnt <= run_cnt + 1'b1;
          end
`endif
        end
        S_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            rr_ptr     <= next_ptr;
            busy       <= 1'b0;
            state      <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_f2d_arbiter.sv
// tb/tb_f2d_arbiter.sv - self-checking bench for f2d_arbiter with converter stub
// Watchdog scenario runs only when F2D_ARB_TIMEOUT_EN is defined.
module tb_f2d_arbiter;

  localparam int N   = 4;
  localparam int TMO = 15;
  localparam int IDW = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [N-1:0]      req_valid;
  logic [32*N-1:0]   req_float;
  logic [N-1:0]      req_ready;
  logic              resp_valid;
  logic              resp_ready;
  logic [IDW-1:0]    resp_id;
  logic [63:0]       resp_double;
  logic              resp_nan;
  logic              busy;
  logic              timeout_err;
  logic              cvt_reset;
  logic [31:0]       cvt_float;
  logic [63:0]       cvt_double;
  logic              cvt_done;
  logic              cvt_nan;

  f2d_arbiter #(.NUM_REQ(N), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_float(req_float),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_double(resp_double), .resp_nan(resp_nan),
    .busy(busy), .timeout_err(timeout_err), .cvt_reset(cvt_reset),
    .cvt_float(cvt_float), .cvt_double(cvt_double), .cvt_done(cvt_done),
    .cvt_nan(cvt_nan)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [64:0] f2d_ref(input logic [31:0] f);
    int p;
    if (f[30:23] == 8'hFF) begin
      if (f[22:0] == 23'd0) return {1'b0, f[31], 11'h7FF, 52'd0};
      return {~f[22], 64'h7FF8000000000000};
    end
    if (f[30:23] == 8'h00) begin
      if (f[22:0] == 23'd0) return {1'b0, f[31], 63'd0};
      p = 0;
      for (int b = 0; b < 23; b++) if (f[b]) p = b;
      return {1'b0, f[31], 11'(p + 874), 52'(52'(f[22:0]) << (52 - p))};
    end
    return {1'b0, f[31], 11'(int'(f[30:23]) + 896), f[22:0], 29'd0};
  endfunction

  function automatic logic [31:0] rand_float();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 5))
      0: return {r[31], 8'hFF, 23'd0};
      1: return {r[31], 8'hFF, 1'b1, r[21:0]};
      2: return {r[31], 8'hFF, 1'b0, (r[21:0] == 22'd0) ? 22'd1 : r[21:0]};
      3: return {r[31], 31'd0};
      4: return {r[31], 8'h00, r[22:1], 1'b1};
      default: return {r[31], 8'(1 + $urandom_range(0, 253)), r[22:0]};
    endcase
  endfunction

  // Converter stub: released by cvt_reset, loads at the first edge, done after 2 (special) or 3 edges.
  int          st_cnt;
  logic [31:0] st_op;
  logic        st_done, st_nan, st_hang, stray;
  logic [63:0] st_dbl;
  always @(posedge clk) begin
    if (!cvt_reset) begin
      st_cnt  <= 0;
      st_done <= 1'b0;
    end else begin
      if (st_cnt < 1000) st_cnt <= st_cnt + 1;
      if (st_cnt == 0) st_op <= cvt_float;
      if (!st_hang && st_cnt >= 1 && (st_cnt + 1) >= ((st_op[30:23] == 8'hFF) ? 2 : 3)) begin
        st_done <= 1'b1;
        {st_nan, st_dbl} <= f2d_ref(st_op);
      end
    end
  end
  assign cvt_done   = st_done | stray;
  assign cvt_double = st_done ? st_dbl : 64'hDEADBEEFDEADBEEF;
  assign cvt_nan    = st_done ? st_nan : 1'b0;

  // Transaction-level reference: remaining cycles until response, owner, expected result.
  logic        m_busy, m_nan, m_hang, m_te;
  int          m_cnt, m_id, m_rr, acc_id;
  logic [63:0] m_dbl;
  logic [31:0] m_op;

  task automatic model_reset();
    m_busy = 1'b0; m_cnt = 0; m_id = 0; m_rr = 0; m_te = 1'b0; m_hang = 1'b0;
  endtask

  task automatic sync();
    @(negedge clk);
    if (m_busy && m_cnt == 0 && m_hang) m_te = 1'b1;
    chk("resp_valid", resp_valid, m_busy && m_cnt == 0);
    chk("busy", busy, m_busy);
    chk("cvt_reset", cvt_reset, m_busy && m_cnt != 0);
    chk("timeout_err", timeout_err, m_te);
    if (m_busy && m_cnt == 0) begin
      chk("resp_id", resp_id, m_id);
      chk("resp_double", resp_double, m_dbl);
      chk("resp_nan", resp_nan, m_nan);
    end
    if (m_busy && m_cnt != 0) chk("cvt_float", cvt_float, m_op);
  endtask

  task automatic commit();
    logic [N-1:0] exp_rdy;
    int g;
    #1;
    g = -1;
    if (!m_busy)
      for (int k = 0; k < N; k++)
        if (g < 0 && req_valid[(m_rr + k) % N]) g = (m_rr + k) % N;
    exp_rdy = (g >= 0) ? (N'(1) << g) : '0;
    chk("req_ready", req_ready, exp_rdy);
    acc_id = g;
    if (!m_busy) begin
      if (g >= 0) begin
        m_busy = 1'b1;
        m_id   = g;
        m_op   = req_float[32*g +: 32];
        m_hang = st_hang;
        if (st_hang) begin
          {m_nan, m_dbl} = {1'b1, 64'h7FF8000000000000};
          m_cnt = TMO;
        end else begin
          {m_nan, m_dbl} = f2d_ref(m_op);
          m_cnt = (m_op[30:23] == 8'hFF) ? 3 : 4;
        end
      end
    end else if (m_cnt == 0) begin
      if (resp_ready) begin
        m_busy = 1'b0;
        m_rr   = (m_id + 1) % N;
      end
    end else begin
      m_cnt--;
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic [31:0] f);
    req_valid[i] = v;
    req_float[32*i +: 32] = f;
  endtask

  task automatic drain();
    for (int k = 0; k < 40; k++) begin
      sync();
      req_valid = '0;
      resp_ready = 1'b1;
      commit();
      if (!m_busy) break;
    end
  endtask

  // Called right after the accepting commit; checks latency and result constants.
  task automatic finish_txn(input string tag, input logic [N-1:0] clr, input logic [63:0] exp_d,
                            input logic exp_n, input int exp_id, input int exp_lat);
    int  k;
    logic seen;
    k = -1;
    seen = 1'b0;
    resp_ready = 1'b1;
    for (int it = 0; it < 40 && !seen; it++) begin
      sync();
      k++;
      req_valid = req_valid & ~clr;
      if (resp_valid) begin
        seen = 1'b1;
        chk({tag, "_lat"}, k, exp_lat);
        chk({tag, "_double"}, resp_double, exp_d);
        chk({tag, "_nan"}, resp_nan, exp_n);
        chk({tag, "_id"}, resp_id, exp_id);
      end
      commit();
    end
    if (!seen) chk({tag, "_resp_wait"}, 0, 1);
  endtask

  initial begin
    int          order[$];
    logic [63:0] snap;
    logic [64:0] r;
    logic        seen;
    reset = 1'b0; req_valid = '0; req_float = '0; resp_ready = 1'b0;
    stray = 1'b0; st_hang = 1'b0;
    model_reset();

    repeat (3) @(negedge clk);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_id", resp_id, 0);
    chk("rst_resp_double", resp_double, 0);
    chk("rst_resp_nan", resp_nan, 0);
    chk("rst_busy", busy, 0);
    chk("rst_timeout_err", timeout_err, 0);
    chk("rst_cvt_reset", cvt_reset, 0);
    chk("rst_cvt_float", cvt_float, 0);
    chk("rst_req_ready", req_ready, 0);
    reset = 1'b1;

    sync(); set_req(0, 1'b1, 32'h3F800000); commit();
    chk("one_acc", acc_id, 0);
    finish_txn("one", 4'b0001, 64'h3FF0000000000000, 1'b0, 0, 4);

    sync(); set_req(2, 1'b1, 32'h7F800000); commit();
    chk("inf_acc", acc_id, 2);
    finish_txn("inf", 4'b0100, 64'h7FF0000000000000, 1'b0, 2, 3);

    sync(); set_req(3, 1'b1, 32'h7FA00000); commit();
    finish_txn("snan", 4'b1000, 64'h7FF8000000000000, 1'b1, 3, 3);

    sync(); stray = 1'b1; commit();
    sync(); commit();
    sync(); stray = 1'b0; commit();

    sync();
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 32'h3F800000 + 32'(i));
    resp_ready = 1'b1;
    commit();
    if (acc_id >= 0) order.push_back(acc_id);
    for (int c = 0; c < 30; c++) begin
      sync(); commit();
      if (acc_id >= 0) order.push_back(acc_id);
    end
    chk("rr_count", order.size() >= 5, 1);
    if (order.size() >= 5) begin
      chk("rr_g0", order[0], 0); chk("rr_g1", order[1], 1); chk("rr_g2", order[2], 2);
      chk("rr_g3", order[3], 3); chk("rr_g4", order[4], 0);
    end
    drain();

    sync(); set_req(0, 1'b1, 32'hC0490FDB); commit();
    sync(); set_req(0, 1'b0, 32'h0); set_req(1, 1'b1, 32'h40490FDB); resp_ready = 1'b0; commit();
    seen = 1'b0;
    for (int it = 0; it < 20 && !seen; it++) begin
      sync();
      if (resp_valid) seen = 1'b1;
      else commit();
    end
    chk("bp_resp_seen", seen, 1);
    snap = resp_double;
    for (int c = 0; c < 10; c++) begin
      commit(); sync();
      chk("bp_hold_double", resp_double, snap);
    end
    resp_ready = 1'b1; commit();
    sync(); commit();
    chk("bp_next_acc", acc_id, 1);
    r = f2d_ref(32'h40490FDB);
    finish_txn("bp", 4'b0010, r[63:0], r[64], 1, 4);

`ifdef F2D_ARB_TIMEOUT_EN
    sync(); st_hang = 1'b1; set_req(1, 1'b1, 32'h3F800000); commit();
    finish_txn("tmo", 4'b0010, 64'h7FF8000000000000, 1'b1, 1, TMO);
    chk("tmo_err", timeout_err, 1);
    st_hang = 1'b0;
    sync(); set_req(2, 1'b1, 32'h3F800000); commit();
    finish_txn("tmo_after", 4'b0100, 64'h3FF0000000000000, 1'b0, 2, 4);
`endif

    sync(); set_req(2, 1'b1, 32'h41200000); commit();
    sync(); req_valid = '0; commit();
    sync(); commit();
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("mid_rst_resp_valid", resp_valid, 0);
    chk("mid_rst_cvt_reset", cvt_reset, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_timeout_err", timeout_err, 0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 8; c++) begin sync(); commit(); end

    for (int c = 0; c < 400; c++) begin
      sync();
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && i != acc_id) begin
          if ($urandom_range(0, 9) == 0) req_valid[i] = 1'b0;
        end else begin
          if ($urandom_range(0, 2) == 0) set_req(i, 1'b1, rand_float());
          else req_valid[i] = 1'b0;
        end
      end
      resp_ready = ($urandom_range(0, 3) != 0);
      commit();
    end
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
